// File: rtl/sum_window_acc.sv
// Windowed accumulator: sums win_len+1 accepted samples, then holds the result for a handshake.
// Define SUM_WINDOW_ACC_SAT_EN to saturate the sum on overflow instead of wrapping.
module sum_window_acc #(
   parameter int unsigned ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   input  logic [7:0]       win_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf
);

   typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [8:0]       cnt_q, cnt_d;
   logic [7:0]       len_q, len_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] acc_add;
   logic             accept;

   assign in_ready = (state_q != StHold);
   assign accept   = in_valid & in_ready;
   assign sum      = {1'b0, acc_q} + (ACC_W+1)'(in_data);

`ifdef SUM_WINDOW_ACC_SAT_EN
   // Once saturated at all-ones, any non-zero add carries again, so the clamp holds.
   assign acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign acc_add = sum[ACC_W-1:0];
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               len_d   = win_len;
               acc_d   = ACC_W'(in_data);
               cnt_d   = 9'd1;
               ovf_d   = 1'b0;
               state_d = (win_len == 8'd0) ? StHold : StAccum;
            end
         end
         StAccum: begin
            if (accept) begin
               acc_d = acc_add;
               cnt_d = cnt_q + 9'd1;
               ovf_d = ovf_q | sum[ACC_W];
               if (cnt_q == {1'b0, len_q}) state_d = StHold;
            end
         end
         StHold: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   // Result registers are frozen in HOLD, so they double as the output registers.
   assign out_valid = (state_q == StHold);
   assign out_data  = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_window_acc.sv
// Directed bench for sum_window_acc with a result scoreboard checked on each output handshake.
module tb_sum_window_acc;

   localparam int unsigned ACC_W = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = 8'd0;
   logic             in_ready;
   logic [7:0]       win_len = 8'd0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_data;
   logic             out_ovf;

   int checks = 0;
   int errors = 0;
   logic [ACC_W:0] exp_q[$];
   logic [ACC_W:0] exp_item;

   always #5 clk = ~clk;

   sum_window_acc #(.ACC_W(ACC_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .win_len  (win_len),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ovf  (out_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // Scoreboard: every completed output handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_item = exp_q.pop_front();
            check("sb_data", 32'(out_data), 32'(exp_item[ACC_W-1:0]));
            check("sb_ovf", 32'(out_ovf), 32'(exp_item[ACC_W]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample and confirm it is accepted at the coming edge; in_valid stays high.
   task automatic send(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      check("in_ready_accept", 32'(in_ready), 32'd1);
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      rst = 1'b0;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Four consecutive samples, result one cycle after the last.
      out_ready = 1'b1;
      win_len   = 8'd3;
      exp_q.push_back({1'b0, 12'd100});
      send(8'd10);
      send(8'd20);
      send(8'd30);
      send(8'd40);
      in_valid = 1'b0;
      check("w4_out_valid", 32'(out_valid), 32'd1);
      tick();
      check("w4_back_idle_valid", 32'(out_valid), 32'd0);
      check("w4_back_idle_ready", 32'(in_ready), 32'd1);

      // Single-sample window.
      win_len = 8'd0;
      exp_q.push_back({1'b0, 12'd255});
      send(8'hFF);
      in_valid = 1'b0;
      check("w1_out_valid", 32'(out_valid), 32'd1);
      check("w1_in_ready", 32'(in_ready), 32'd0);
      tick();

      // Gapped samples; win_len change mid-window is ignored.
      win_len = 8'd1;
      exp_q.push_back({1'b0, 12'd12});
      send(8'd5);
      idle(1);
      win_len = 8'd9;
      idle(2);
      check("gap_no_valid", 32'(out_valid), 32'd0);
      send(8'd7);
      in_valid = 1'b0;
      check("gap_out_valid", 32'(out_valid), 32'd1);
      tick();

      // Backpressure: result held, no sample accepted until the handshake completes.
      out_ready = 1'b0;
      win_len   = 8'd3;
      exp_q.push_back({1'b0, 12'd100});
      send(8'd25);
      send(8'd25);
      send(8'd25);
      send(8'd25);
      in_data = 8'd99;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_data", 32'(out_data), 32'd100);
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("bp_after_valid", 32'(out_valid), 32'd0);
      check("bp_after_ready", 32'(in_ready), 32'd1);
      win_len = 8'd0;
      exp_q.push_back({1'b0, 12'd3});
      send(8'd3);
      in_valid = 1'b0;
      check("bp_next_valid", 32'(out_valid), 32'd1);
      tick();

      // Overflow over seventeen samples of 255 (4335 total).
      win_len = 8'd16;
`ifdef SUM_WINDOW_ACC_SAT_EN
      exp_q.push_back({1'b1, 12'd4095});
`else
      exp_q.push_back({1'b1, 12'd239});
`endif
      for (int i = 0; i < 17; i++) send(8'd255);
      in_valid = 1'b0;
      check("ovf_out_valid", 32'(out_valid), 32'd1);
      check("ovf_flag", 32'(out_ovf), 32'd1);
      tick();

      // Reset mid-window discards the partial sum.
      win_len = 8'd3;
      send(8'd50);
      send(8'd60);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      idle(2);
      check("mid_rst_no_emit", 32'(out_valid), 32'd0);
      exp_q.push_back({1'b0, 12'd4});
      send(8'd1);
      send(8'd1);
      send(8'd1);
      send(8'd1);
      in_valid = 1'b0;
      check("post_rst_valid", 32'(out_valid), 32'd1);
      tick();
      idle(2);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sum_window_acc.md
SUM_WINDOW_ACC -- requirements
Module: sum_window_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator and result width in bits; legal range 8..16.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: the upstream 8-bit sum on in_data is valid this cycle.
REQ-005 SHALL have port in_data, input, 8: unsigned sample; this is the 8-bit sum produced by the upstream adder stage.
REQ-006 SHALL have port in_ready, output, 1: this block accepts a sample this cycle.
REQ-007 SHALL have port win_len, input, 8: window size minus one; a window is win_len+1 samples (1..256).
REQ-008 SHALL have port out_valid, output, 1: the window result is valid.
REQ-009 SHALL have port out_ready, input, 1: the downstream stage accepts the result.
REQ-010 SHALL have port out_data, output, ACC_W: the window sum.
REQ-011 SHALL have port out_ovf, output, 1: the accumulator exceeded 2^ACC_W-1 during this window.

Function
REQ-012 SHALL treat a sample as accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-013 SHALL implement three states: IDLE, ACCUM and HOLD.
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-015 SHALL, in IDLE on an accepted sample, latch win_len, load acc=in_data, set cnt=1, clear ovf, and go to ACCUM, or go directly to HOLD if the latched win_len=0.
REQ-016 SHALL, in ACCUM on an accepted sample, add in_data to acc and increment cnt; when cnt reaches latched win_len+1 on that sample, go to HOLD.
REQ-017 SHALL ignore changes to win_len after the first sample of a window has been latched.
REQ-018 SHALL hold state, acc and cnt unchanged in ACCUM while in_valid=0, with no timeout.
REQ-019 SHALL present the result with 1-cycle latency: out_valid=1 in the cycle after the last sample is accepted.
REQ-020 SHALL assert out_valid=1 only in HOLD.
REQ-021 SHALL hold out_data and out_ovf stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, in HOLD with out_ready=1, complete the handshake and go to IDLE.
REQ-023 SHALL NOT accept a new sample in the cycle of the out_valid/out_ready handshake; the next window starts at the earliest in the following cycle.
REQ-024 SHALL drive out_ready as don't-care outside HOLD.
REQ-025 SHALL compute the accumulator sum with at least ACC_W+1 bits internally.
REQ-026 SHALL set out_ovf whenever a carry out of bit ACC_W-1 occurs; out_ovf is sticky until the next window starts.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_data=0 and out_ovf=0.
REQ-028 SHALL give in_ready=1 in the first cycle after rst deasserts.
REQ-029 SHALL, on reset mid-window or during HOLD, discard the partial or pending result without emitting it.
REQ-030 SHALL give rst priority over any simultaneous in_valid or out_ready.

Configuration
REQ-031 SHALL support macro SUM_WINDOW_ACC_SAT_EN.
REQ-032 SHALL, when SUM_WINDOW_ACC_SAT_EN is defined, clamp acc at 2^ACC_W-1 on overflow and hold it there for the rest of the window.
REQ-033 SHALL, when SUM_WINDOW_ACC_SAT_EN is undefined, wrap acc modulo 2^ACC_W.
REQ-034 SHALL set out_ovf identically with or without SUM_WINDOW_ACC_SAT_EN.

Verification
REQ-035 SHALL cover: win_len=3, samples 10,20,30,40 on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after the 4th sample, out_data=100, out_ovf=0, then IDLE.
REQ-036 SHALL cover: win_len=0, single sample 0xFF -> out_valid next cycle, out_data=255, and in_ready=0 for that cycle.
REQ-037 SHALL cover: win_len=1, samples 5 and 7 separated by 3 in_valid=0 cycles -> out_data=12; win_len changed to 9 mid-window has no effect.
REQ-038 SHALL cover: result 100 with out_ready=0 for 5 cycles and in_valid=1 throughout -> out_data held at 100, in_ready=0, no sample accepted until the handshake.
REQ-039 SHALL cover: ACC_W=12, win_len=16, seventeen samples of 255 -> with macro out_data=4095, out_ovf=1; without macro out_data=239, out_ovf=1.
REQ-040 SHALL cover: rst pulsed after 2 of 4 samples -> no out_valid; a following window of 1,1,1,1 -> out_data=4.
